// File: rtl/pipeline_stall_ctrl_if.sv
// pipeline_stall_ctrl_if: hazard/cache/redirect inputs (master drives) and stage controls, watchdog, stall counter (slave drives)
interface pipeline_stall_ctrl_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
);
  logic             IDEX_MemRead;
  logic [REG_W-1:0] IDEX_RegRt;
  logic [REG_W-1:0] IFID_RegRs;
  logic [REG_W-1:0] IFID_RegRt;
  logic             ICache_stall;
  logic             DCache_stall;
  logic             BranchTaken;
  logic             Jump;
  logic             PCWrite;
  logic             IFIDWrite;
  logic             IFIDFlush;
  logic             IDEXBubble;
  logic             PipeHold;
  logic             hold_timeout;
  logic [CNT_W-1:0] stall_cnt;
  modport master (
    output IDEX_MemRead, IDEX_RegRt, IFID_RegRs, IFID_RegRt,
           ICache_stall, DCache_stall, BranchTaken, Jump,
    input  PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, PipeHold,
           hold_timeout, stall_cnt
  );
  modport slave (
    input  IDEX_MemRead, IDEX_RegRt, IFID_RegRs, IFID_RegRt,
           ICache_stall, DCache_stall, BranchTaken, Jump,
    output PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, PipeHold,
           hold_timeout, stall_cnt
  );
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl: prioritised stall/flush sequencer (clk, rst, bus: hazard/cache/redirect in; PC/IFID/IDEX/hold controls, hold_timeout, stall_cnt out)
module pipeline_stall_ctrl #(
  parameter int REG_W    = 5,
  parameter int CNT_W    = 16,
  parameter int MAX_HOLD = 64
) (
  input logic clk,
  input logic rst,
  pipeline_stall_ctrl_if.slave bus
);
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HMAX = HW'(MAX_HOLD);
  typedef enum logic [1:0] {RUN, HOLD, BUBBLE} state_t;
  state_t           r_state, w_next;
  logic             r_flush_pending, w_flush_pending;
  logic [HW-1:0]    r_hold_len, w_hold_len;
  logic             r_hold_timeout;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_cache, w_redirect, w_loaduse;
  logic             w_pc, w_ifw, w_flush, w_bubble, w_hold;
  assign w_cache    = bus.ICache_stall | bus.DCache_stall;
  assign w_redirect = bus.BranchTaken | bus.Jump;
  assign w_loaduse  = bus.IDEX_MemRead && bus.IDEX_RegRt != '0 &&
                      (bus.IDEX_RegRt == bus.IFID_RegRs || bus.IDEX_RegRt == bus.IFID_RegRt);
  assign w_hold_len = w_cache ? (r_hold_len == HMAX ? r_hold_len : r_hold_len + 1'b1) : '0;
  always_comb begin
    w_next          = RUN;
    w_flush_pending = r_flush_pending;
    w_pc            = 1'b1;
    w_ifw           = 1'b1;
    w_flush         = 1'b0;
    w_bubble        = 1'b0;
    w_hold          = 1'b0;
    if (w_cache) begin
      w_pc            = 1'b0;
      w_ifw           = 1'b0;
      w_hold          = 1'b1;
      w_flush_pending = r_flush_pending | w_redirect;
      w_next          = HOLD;
    end else if (r_flush_pending) begin
      w_flush         = 1'b1;
      w_flush_pending = 1'b0;
    end else if (w_loaduse && r_state != BUBBLE) begin
      w_pc     = 1'b0;
      w_ifw    = 1'b0;
      w_bubble = 1'b1;
      w_next   = BUBBLE;
    end else if (w_redirect) begin
      w_flush = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= RUN;
      r_flush_pending <= 1'b0;
      r_hold_len      <= '0;
      r_hold_timeout  <= 1'b0;
      r_stall_cnt     <= '0;
    end else begin
      r_state         <= w_next;
      r_flush_pending <= w_flush_pending;
      r_hold_len      <= w_hold_len;
      r_hold_timeout  <= r_hold_timeout | (w_hold_len == HMAX);
      r_stall_cnt     <= r_stall_cnt + CNT_W'(!w_pc && r_stall_cnt != '1);
    end
  end
  assign bus.PCWrite      = w_pc;
  assign bus.IFIDWrite    = w_ifw;
  assign bus.IFIDFlush    = w_flush;
  assign bus.IDEXBubble   = w_bubble;
  assign bus.PipeHold     = w_hold;
  assign bus.hold_timeout = r_hold_timeout;
  assign bus.stall_cnt    = r_stall_cnt;
endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// tb_pipeline_stall_ctrl: randomized and directed checks of pipeline_stall_ctrl against a behavioural model
module tb_pipeline_stall_ctrl;
  logic clk = 1'b0;
  logic r = 1'b1, mr = 1'b0, ic = 1'b0, dc = 1'b0, bt = 1'b0, j = 1'b0;
  logic [4:0] rt = '0, rs = '0, rtt = '0;
  int total = 0, bad = 0;
  bit m_fp, m_bub, m_to;
  int m_hold, m_cnt0, m_cnt1;
  logic [4:0] exp_ctl, obs_ctl;
  logic [15:0] obs_cnt0;
  logic [3:0] obs_cnt1;
  logic obs_to, obs_to1;
  always #5 clk = ~clk;
  pipeline_stall_ctrl_if #(.REG_W(5), .CNT_W(16)) bus0 ();
  pipeline_stall_ctrl_if #(.REG_W(5), .CNT_W(4))  bus1 ();
  assign bus0.IDEX_MemRead = mr;  assign bus1.IDEX_MemRead = mr;
  assign bus0.IDEX_RegRt   = rt;  assign bus1.IDEX_RegRt   = rt;
  assign bus0.IFID_RegRs   = rs;  assign bus1.IFID_RegRs   = rs;
  assign bus0.IFID_RegRt   = rtt; assign bus1.IFID_RegRt   = rtt;
  assign bus0.ICache_stall = ic;  assign bus1.ICache_stall = ic;
  assign bus0.DCache_stall = dc;  assign bus1.DCache_stall = dc;
  assign bus0.BranchTaken  = bt;  assign bus1.BranchTaken  = bt;
  assign bus0.Jump         = j;   assign bus1.Jump         = j;
  pipeline_stall_ctrl #(.REG_W(5), .CNT_W(16), .MAX_HOLD(64)) u0 (.clk(clk), .rst(r), .bus(bus0));
  pipeline_stall_ctrl #(.REG_W(5), .CNT_W(4),  .MAX_HOLD(64)) u1 (.clk(clk), .rst(r), .bus(bus1));
  // One clock: sample controls mid-cycle, advance the model across the edge, then sample registers.
  task automatic tick();
    bit redir, cache, lu, n_fp, n_bub;
    #1;
    redir = bt | j;
    cache = ic | dc;
    lu    = mr && rt != 0 && (rt == rs || rt == rtt);
    obs_ctl = {bus0.PCWrite, bus0.IFIDWrite, bus0.IFIDFlush, bus0.IDEXBubble, bus0.PipeHold};
    n_fp = 0;
    n_bub = 0;
    if (cache) begin
      exp_ctl = 5'b00001;
      n_fp = m_fp | redir;
    end else if (m_fp) exp_ctl = 5'b11100;
    else if (lu && !m_bub) begin
      exp_ctl = 5'b00010;
      n_bub = 1;
    end else exp_ctl = redir ? 5'b11100 : 5'b11000;
    @(posedge clk);
    if (r) begin
      m_fp = 0; m_bub = 0; m_hold = 0; m_to = 0; m_cnt0 = 0; m_cnt1 = 0;
    end else begin
      m_fp = n_fp;
      m_bub = n_bub;
      m_hold = cache ? (m_hold < 64 ? m_hold + 1 : 64) : 0;
      if (m_hold == 64) m_to = 1;
      if (!exp_ctl[4]) begin
        if (m_cnt0 < 65535) m_cnt0++;
        if (m_cnt1 < 15) m_cnt1++;
      end
    end
    #1;
    obs_cnt0 = bus0.stall_cnt;
    obs_cnt1 = bus1.stall_cnt;
    obs_to   = bus0.hold_timeout;
    obs_to1  = bus1.hold_timeout;
  endtask
  task automatic test_reset();
    r = 1;
    repeat (2) begin
      tick();
      total += 3;
      if (obs_ctl !== 5'b11000) begin bad++; $display("FAIL reset_ctl got=%b exp=11000", obs_ctl); end
      if (obs_cnt0 !== 16'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", obs_cnt0); end
      if (obs_to !== 1'b0) begin bad++; $display("FAIL reset_timeout got=%b exp=0", obs_to); end
    end
    r = 0;
  endtask
  task automatic test_loaduse();
    int c0 = m_cnt0;
    mr = 1; rt = 8; rs = 8; rtt = 3;
    for (int i = 0; i < 2; i++) begin
      tick();
      total += 3;
      if (obs_ctl !== exp_ctl) begin bad++; $display("FAIL loaduse_model got=%b exp=%b", obs_ctl, exp_ctl); end
      if (obs_ctl !== (i == 0 ? 5'b00010 : 5'b11000)) begin bad++; $display("FAIL loaduse_ctl%0d got=%b", i, obs_ctl); end
      if (obs_cnt0 !== 16'(m_cnt0)) begin bad++; $display("FAIL loaduse_cnt got=%0d exp=%0d", obs_cnt0, m_cnt0); end
    end
    total++;
    if (obs_cnt0 !== 16'(c0 + 1)) begin bad++; $display("FAIL loaduse_cnt1 got=%0d exp=%0d", obs_cnt0, c0 + 1); end
    rt = 0; rs = 0;
    repeat (2) begin
      tick();
      total++;
      if (obs_ctl !== 5'b11000) begin bad++; $display("FAIL loaduse_r0 got=%b exp=11000", obs_ctl); end
    end
    mr = 0;
  endtask
  task automatic test_dcache_jump();
    int c0 = m_cnt0;
    for (int i = 0; i < 4; i++) begin
      dc = (i < 3);
      j = (i == 1);
      tick();
      total += 3;
      if (obs_ctl !== exp_ctl) begin bad++; $display("FAIL dhold_model got=%b exp=%b", obs_ctl, exp_ctl); end
      if (obs_ctl !== (i < 3 ? 5'b00001 : 5'b11100)) begin bad++; $display("FAIL dhold_ctl%0d got=%b", i, obs_ctl); end
      if (obs_cnt0 !== 16'(m_cnt0)) begin bad++; $display("FAIL dhold_cnt got=%0d exp=%0d", obs_cnt0, m_cnt0); end
    end
    dc = 0; j = 0;
    total++;
    if (obs_cnt0 !== 16'(c0 + 3)) begin bad++; $display("FAIL dhold_cnt3 got=%0d exp=%0d", obs_cnt0, c0 + 3); end
  endtask
  task automatic test_branch_loaduse();
    mr = 1; rt = 5; rs = 5; bt = 1;
    tick();
    total++;
    if (obs_ctl !== 5'b00010) begin bad++; $display("FAIL br_lu got=%b exp=00010", obs_ctl); end
    mr = 0;
    tick();
    total++;
    if (obs_ctl !== 5'b11100) begin bad++; $display("FAIL br_alone got=%b exp=11100", obs_ctl); end
    bt = 0; rt = 0; rs = 0;
    tick();
  endtask
  task automatic test_watchdog();
    ic = 1;
    for (int i = 1; i <= 64; i++) begin
      tick();
      total += 2;
      if (obs_to !== (i == 64)) begin bad++; $display("FAIL wd_edge%0d got=%b", i, obs_to); end
      if (obs_to !== m_to) begin bad++; $display("FAIL wd_model got=%b exp=%b", obs_to, m_to); end
    end
    ic = 0;
    tick();
    total += 2;
    if (obs_to !== 1'b1) begin bad++; $display("FAIL wd_sticky got=%b exp=1", obs_to); end
    if (obs_ctl !== 5'b11000) begin bad++; $display("FAIL wd_release got=%b exp=11000", obs_ctl); end
    r = 1;
    tick();
    r = 0;
    total++;
    if (obs_to !== 1'b0) begin bad++; $display("FAIL wd_clear got=%b exp=0", obs_to); end
  endtask
  task automatic test_saturate();
    r = 1;
    tick();
    r = 0;
    dc = 1;
    repeat (20) begin
      tick();
      total++;
      if (obs_cnt1 !== 4'(m_cnt1)) begin bad++; $display("FAIL sat_model got=%0d exp=%0d", obs_cnt1, m_cnt1); end
    end
    total += 2;
    if (obs_cnt1 !== 4'd15) begin bad++; $display("FAIL sat_cnt4 got=%0d exp=15", obs_cnt1); end
    if (obs_cnt0 !== 16'd20) begin bad++; $display("FAIL sat_cnt16 got=%0d exp=20", obs_cnt0); end
    r = 1;
    tick();
    total += 3;
    if (obs_ctl !== 5'b00001) begin bad++; $display("FAIL sat_rst_ctl got=%b exp=00001", obs_ctl); end
    if (obs_cnt0 !== 16'd0) begin bad++; $display("FAIL sat_rst_cnt16 got=%0d exp=0", obs_cnt0); end
    if (obs_cnt1 !== 4'd0) begin bad++; $display("FAIL sat_rst_cnt4 got=%0d exp=0", obs_cnt1); end
    r = 0; dc = 0;
    tick();
    total++;
    if (obs_ctl !== 5'b11000) begin bad++; $display("FAIL sat_run got=%b exp=11000", obs_ctl); end
  endtask
  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      r   = ($urandom_range(0, 79) == 0);
      mr  = $urandom_range(0, 1);
      rt  = 5'($urandom_range(0, 3));
      rs  = 5'($urandom_range(0, 3));
      rtt = 5'($urandom_range(0, 3));
      ic  = (i % 100 > 80) || ($urandom_range(0, 9) == 0);
      dc  = ($urandom_range(0, 7) == 0);
      bt  = ($urandom_range(0, 4) == 0);
      j   = ($urandom_range(0, 5) == 0);
      tick();
      total += 5;
      if (obs_ctl !== exp_ctl) begin bad++; $display("FAIL rnd_ctl cyc=%0d got=%b exp=%b", i, obs_ctl, exp_ctl); end
      if (obs_cnt0 !== 16'(m_cnt0)) begin bad++; $display("FAIL rnd_cnt16 cyc=%0d got=%0d exp=%0d", i, obs_cnt0, m_cnt0); end
      if (obs_cnt1 !== 4'(m_cnt1)) begin bad++; $display("FAIL rnd_cnt4 cyc=%0d got=%0d exp=%0d", i, obs_cnt1, m_cnt1); end
      if (obs_to !== m_to) begin bad++; $display("FAIL rnd_to cyc=%0d got=%b exp=%b", i, obs_to, m_to); end
      if (obs_to1 !== m_to) begin bad++; $display("FAIL rnd_to4 cyc=%0d got=%b exp=%b", i, obs_to1, m_to); end
    end
    r = 0; mr = 0; ic = 0; dc = 0; bt = 0; j = 0;
  endtask
  initial begin
    test_reset();
    test_loaduse();
    test_dcache_jump();
    test_branch_loaduse();
    test_watchdog();
    test_saturate();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipeline_stall_ctrl.md
Name: pipeline_stall_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage MIPS pipeline. Replaces ad-hoc per-stage enables.
- Combines load-use hazard detection (ID vs EX), I/D cache miss stalls and branch/jump redirects into one prioritised set of stage controls.
- Small FSM guarantees single-bubble insertion, defers redirects that arrive during a cache hold, watches for runaway holds and counts stall cycles.

Parameters:
REG_W, 5, register specifier width
CNT_W, 16, width of the stall performance counter
MAX_HOLD, 64, consecutive cache-hold cycles before hold_timeout is raised

Ports:
clk  in  1  pipeline clock
rst  in  1  synchronous reset, active high
IDEX_MemRead  in  1  instruction in EX is a load
IDEX_RegRt  in  REG_W  destination register of load in EX
IFID_RegRs  in  REG_W  rs of instruction in ID
IFID_RegRt  in  REG_W  rt of instruction in ID
ICache_stall  in  1  instruction cache miss in progress
DCache_stall  in  1  data cache miss in progress
BranchTaken  in  1  one-cycle redirect pulse, branch resolved taken
Jump  in  1  one-cycle redirect pulse, jump in ID
PCWrite  out  1  PC update enable
IFIDWrite  out  1  IF/ID register enable
IFIDFlush  out  1  zero IF/ID on next edge
IDEXBubble  out  1  zero control fields into ID/EX on next edge
PipeHold  out  1  freeze ID/EX, EX/MEM, MEM/WB
hold_timeout  out  1  sticky: hold exceeded MAX_HOLD
stall_cnt  out  CNT_W  saturating count of cycles with PCWrite=0

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst` is synchronous and active high.
- Reset: FSM goes to RUN; flush_pending=0, hold_len=0, hold_timeout=0, stall_cnt=0.
- Stage-control outputs are combinational from state plus inputs, with no added latency. hold_timeout and stall_cnt are registered.
- Default (RUN, no event): PCWrite=1, IFIDWrite=1, IFIDFlush=0, IDEXBubble=0, PipeHold=0.
- While rst is high, the stage-control outputs follow these same combinational rules.
- redirect = BranchTaken | Jump.
- loaduse = IDEX_MemRead & (IDEX_RegRt != 0) & ((IDEX_RegRt == IFID_RegRs) | (IDEX_RegRt == IFID_RegRt)).
  - Register $0 never creates a hazard.
- Per-cycle priority, highest first:
  1. Cache stall (ICache_stall | DCache_stall):
     - Outputs: PipeHold=1, PCWrite=0, IFIDWrite=0, IFIDFlush=0, IDEXBubble=0.
     - If redirect is high, set flush_pending.
     - Next state HOLD.
  2. flush_pending=1:
     - Outputs: IFIDFlush=1, PCWrite=1, IFIDWrite=1.
     - Clear flush_pending. loaduse is ignored this cycle. Next state RUN.
  3. loaduse and state != BUBBLE:
     - Outputs: PCWrite=0, IFIDWrite=0, IDEXBubble=1.
     - Next state BUBBLE. A redirect in the same cycle is ignored, because the ID instruction re-issues.
  4. redirect:
     - Outputs: IFIDFlush=1, PCWrite=1, IFIDWrite=1. Next state RUN.
  5. Otherwise: default outputs. Next state RUN.
- States:
  - RUN: normal operation.
  - HOLD: cache stall was seen last cycle.
  - BUBBLE: a bubble was inserted last cycle. loaduse is masked, so at most one consecutive bubble is inserted per hazard.
  - BUBBLE exits to RUN, or to HOLD on a cache stall.
- Hold watchdog:
  - hold_len increments on every cache-stall cycle, saturating at MAX_HOLD, and clears on any non-stall cycle.
  - When hold_len reaches MAX_HOLD, hold_timeout is set on that edge and stays set until rst.
  - Pipeline behaviour is unaffected.
- stall_cnt:
  - Increments on every edge where PCWrite=0, rst is low and stall_cnt is not all-ones.
  - Holds at 2^CNT_W-1 once reached.
- Simultaneous I- and D-cache stall: treated as a single hold.
- A redirect that arrives during flush_pending leaves the flag set. Only one flush is issued.
- A cache stall arriving in the cycle flush_pending would release keeps the flush deferred (priority 1 wins).

Test Plan:
1. Reset sequence: rst=1 for 2 cycles → outputs 1,1,0,0,0; stall_cnt=0; hold_timeout=0; state RUN.
2. Load-use: IDEX_MemRead=1, IDEX_RegRt=8, IFID_RegRs=8, held for 2 cycles → IDEXBubble=1, PCWrite=0 in cycle 1 only; cycle 2 default; stall_cnt=1. Repeat with IDEX_RegRt=0 → no stall.
3. DCache_stall for 3 cycles with Jump pulsed in cycle 2 → PipeHold=1, PCWrite=0 for 3 cycles, no flush during the hold; cycle 4 IFIDFlush=1, PCWrite=1; stall_cnt=3.
4. BranchTaken together with loaduse in RUN → IDEXBubble=1, IFIDFlush=0. BranchTaken alone next cycle → IFIDFlush=1.
5. ICache_stall held for MAX_HOLD=64 cycles → hold_timeout rises on edge 64 and stays 1 after the stall drops; it clears only after rst.
6. CNT_W=4 build with 20 consecutive stall cycles → stall_cnt saturates at 15. Reset asserted mid-hold → next cycle state RUN, stall_cnt=0.
